// File: rtl/conv_accum9_pkg.sv
// conv_pkg: default sizes, state encoding and saturation limit for conv_accum9.
package conv_pkg;
  localparam int TAPS_DEF = 9;
  localparam int IN_W_DEF = 8;
  localparam int ACC_W_DEF = 12;
  localparam int SAT_LIM = 2**(IN_W_DEF-1)-1;
  typedef enum logic {ST_ACC, ST_OUT} state_t;
endpackage

// File: rtl/conv_accum9_if.sv
// conv_accum9_if: tap input stream, frame abort and result output handshake.
interface conv_accum9_if #(parameter int IN_W = 8, parameter int ACC_W = 12);
  logic clear;
  logic [IN_W-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic [ACC_W-1:0] out_sum;
  logic [IN_W-1:0] out_sm;
  logic out_sat;
  logic out_valid;
  logic out_ready;
  modport master(output clear, in_data, in_valid, out_ready, input in_ready, out_sum, out_sm, out_sat, out_valid);
  modport slave(input clear, in_data, in_valid, out_ready, output in_ready, out_sum, out_sm, out_sat, out_valid);
endinterface

// File: rtl/conv_accum9_sm_to_tc.sv
// sm_to_tc: sign-magnitude to sign-extended two's complement; negative zero maps to 0.
module sm_to_tc #(parameter int IN_W = 8, parameter int ACC_W = 12) (
  input  logic [IN_W-1:0]  sm,
  output logic [ACC_W-1:0] tc
);
  logic [ACC_W-1:0] mag;
  assign mag = ACC_W'(sm[IN_W-2:0]);
  assign tc = sm[IN_W-1] ? -mag : mag;
endmodule

// File: rtl/conv_accum9.sv
// conv_accum9: sums TAPS sign-magnitude products per pixel, emits two's-complement and saturated sign-magnitude results.
module conv_accum9
  import conv_pkg::*;
#(
  parameter int TAPS = TAPS_DEF,
  parameter int IN_W = IN_W_DEF,
  parameter int ACC_W = ACC_W_DEF
) (
  input logic clk,
  input logic rst_n,
  conv_accum9_if.slave bus
);
  localparam int CW = $clog2(TAPS);
  localparam logic [ACC_W-1:0] LIM = ACC_W'(2**(IN_W-1)-1);
  if (ACC_W < $clog2(TAPS*(2**(IN_W-1)-1))+1) begin : g_acc_w_check
    $error("conv_accum9: ACC_W too narrow for TAPS full-scale products");
  end
  state_t state;
  logic live;
  logic [CW-1:0] tap_cnt;
  logic [ACC_W-1:0] acc, tap, sum, mag;
  logic neg, sat, take, last;
  sm_to_tc #(.IN_W(IN_W), .ACC_W(ACC_W)) u_sm_to_tc (.sm(bus.in_data), .tc(tap));
  always_comb begin
    sum = acc + tap;
    neg = sum[ACC_W-1];
    mag = neg ? -sum : sum;
    sat = mag > LIM;
    take = bus.in_valid && bus.in_ready;
    last = tap_cnt == CW'(TAPS-1);
  end
  // live holds in_ready low until the first edge after reset release
  assign bus.in_ready = live && state == ST_ACC && !bus.clear;
  assign bus.out_valid = state == ST_OUT;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACC;
      live <= 1'b0;
      acc <= '0;
      tap_cnt <= '0;
      bus.out_sum <= '0;
      bus.out_sm <= '0;
      bus.out_sat <= 1'b0;
    end else begin
      live <= 1'b1;
      if (state == ST_ACC) begin
        if (bus.clear) begin
          acc <= '0;
          tap_cnt <= '0;
        end else if (take && last) begin
          bus.out_sum <= sum;
          bus.out_sm <= {neg, sat ? LIM[IN_W-2:0] : mag[IN_W-2:0]};
          bus.out_sat <= sat;
          acc <= '0;
          tap_cnt <= '0;
          state <= ST_OUT;
        end else if (take) begin
          acc <= sum;
          tap_cnt <= tap_cnt + CW'(1);
        end
      end else if (bus.out_ready) begin
        state <= ST_ACC;
      end
    end
  end
endmodule
